// File: rtl/im_loader.sv
// Sequential loader for the big-endian byte-addressed instruction memory.
// It splits each accepted 32-bit word into four MSB-first byte writes.
module im_loader #(
  parameter int MEM_SIZE = 128,
  parameter int ADDR_W   = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [5:0]        load_len,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [31:0]       in_word,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic [5:0]        words_loaded
);

  localparam logic [5:0] FULL_LEN = 6'(MEM_SIZE / 4);

  typedef enum logic [1:0] {
    IDLE,
    ACCEPT,
    WRITE,
    DONE
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] addr;
  logic [5:0]        len;
  logic [1:0]        byte_idx;
  logic [23:0]       word;
  logic [7:0]        next_byte;
  logic [5:0]        words_inc;

  assign words_inc = words_loaded + 6'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (load_start) begin
          state_next = ACCEPT;
        end
      end
      ACCEPT: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        busy = 1'b1;
        if (byte_idx == 2'd3) begin
          state_next = (words_inc == len) ? DONE : ACCEPT;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (abort) begin
      state_next = IDLE;
    end
  end

  // The top byte goes out on the handshake edge, so only the lower 24 bits are kept.
  always_comb begin
    next_byte = word[7:0];
    case (byte_idx)
      2'd0:    next_byte = word[23:16];
      2'd1:    next_byte = word[15:8];
      default: next_byte = word[7:0];
    endcase
  end

  // Write outputs are registered one cycle ahead of the byte index they display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr         <= '0;
      len          <= '0;
      byte_idx     <= '0;
      word         <= '0;
      words_loaded <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
    end else begin
      wr_en <= 1'b0;
      if (!abort) begin
        case (state)
          IDLE: begin
            if (load_start) begin
              addr         <= base_addr & ~ADDR_W'(3);
              len          <= (load_len == 6'd0) ? FULL_LEN : load_len;
              words_loaded <= '0;
            end
          end
          ACCEPT: begin
            if (in_valid) begin
              word     <= in_word[23:0];
              byte_idx <= 2'd0;
              wr_en    <= 1'b1;
              wr_addr  <= addr;
              wr_data  <= in_word[31:24];
              addr     <= addr + 1'b1;
            end
          end
          WRITE: begin
            if (byte_idx != 2'd3) begin
              wr_en    <= 1'b1;
              wr_addr  <= addr;
              wr_data  <= next_byte;
              addr     <= addr + 1'b1;
              byte_idx <= byte_idx + 2'd1;
            end else begin
              words_loaded <= words_inc;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: a byte-memory monitor records every write
// and each step compares against hand-computed addresses, bytes and counts.
module tb_im_loader;

  logic        clk;
  logic        rst_n;
  logic        load_start;
  logic [6:0]  base_addr;
  logic [5:0]  load_len;
  logic        abort;
  logic        in_valid;
  logic [31:0] in_word;
  logic        in_ready;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        done;
  logic [5:0]  words_loaded;

  int vectors;
  int miscompares;

  logic [7:0] mem [128];
  int         hits [128];
  int         hits0 [128];
  int         wr_count;
  int         done_count;
  int         bad_wr;

  im_loader #(.MEM_SIZE(128), .ADDR_W(7)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_start   (load_start),
    .base_addr    (base_addr),
    .load_len     (load_len),
    .abort        (abort),
    .in_valid     (in_valid),
    .in_word      (in_word),
    .in_ready     (in_ready),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .busy         (busy),
    .done         (done),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behaves as the instruction memory and flags writes outside a busy WRITE phase.
  always @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr]  <= wr_data;
      hits[wr_addr] <= hits[wr_addr] + 1;
      wr_count      <= wr_count + 1;
    end
    if (done) done_count <= done_count + 1;
    if (wr_en && (in_ready || done || !busy)) bad_wr <= bad_wr + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [6:0] base, input logic [5:0] len);
    base_addr  = base;
    load_len   = len;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  // Returns one cycle after the handshake edge, i.e. with byte 0 on the write port.
  task automatic send_word(input logic [31:0] w);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_word  = w;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!in_ready) begin
      check_output("handshake_timeout", {31'd0, in_ready}, 32'd1);
    end else begin
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int wc0;
    int dc0;
    int bad_addrs;

    vectors     = 0;
    miscompares = 0;
    wr_count    = 0;
    done_count  = 0;
    bad_wr      = 0;
    for (int i = 0; i < 128; i++) begin
      mem[i]   = 8'h00;
      hits[i]  = 0;
      hits0[i] = 0;
    end
    rst_n      = 1'b0;
    load_start = 1'b0;
    base_addr  = '0;
    load_len   = '0;
    abort      = 1'b0;
    in_valid   = 1'b0;
    in_word    = '0;

    #12;
    check_output("reset_outputs", {16'd0, in_ready, wr_en, busy, done, wr_addr, wr_data, words_loaded}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    $display("[TB] single word");
    apply_stimulus(7'h00, 6'd1);
    check_output("accept_after_start", {30'd0, in_ready, busy}, 32'd3);
    send_word(32'h8C010004);
    check_output("w1_b0", {16'd0, wr_en, wr_addr, wr_data}, {16'd0, 1'b1, 7'h00, 8'h8C});
    tick();
    check_output("w1_b1", {16'd0, wr_en, wr_addr, wr_data}, {16'd0, 1'b1, 7'h01, 8'h01});
    tick();
    check_output("w1_b2", {16'd0, wr_en, wr_addr, wr_data}, {16'd0, 1'b1, 7'h02, 8'h00});
    tick();
    check_output("w1_b3", {16'd0, wr_en, wr_addr, wr_data}, {16'd0, 1'b1, 7'h03, 8'h04});
    tick();
    check_output("w1_done", {26'd0, done, busy, wr_en, in_ready, 2'b00}, {26'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00});
    check_output("w1_words_loaded", {26'd0, words_loaded}, 32'd1);
    tick();
    check_output("w1_done_one_cycle", {31'd0, done}, 32'd0);

    $display("[TB] backpressure");
    wc0 = wr_count;
    apply_stimulus(7'h00, 6'd3);
    for (int w = 0; w < 3; w++) begin
      bad_addrs = 0;
      for (int s = 0; s < 4; s++) begin
        if (!in_ready || wr_en) bad_addrs++;
        tick();
      end
      check_output("stall_ready_no_write", bad_addrs, 32'd0);
      send_word(32'h10111213 + 32'h10101010 * w);
      repeat (4) tick();
    end
    check_output("bp_done", {31'd0, done}, 32'd1);
    check_output("bp_write_count", wr_count - wc0, 32'd12);
    check_output("bp_words_loaded", {26'd0, words_loaded}, 32'd3);
    check_output("bp_mem", {mem[8'h00], mem[8'h04], mem[8'h0B], mem[8'h06]}, 32'h10203322);
    tick();

    $display("[TB] wrap and alignment");
    apply_stimulus(7'h7E, 6'd2);
    send_word(32'h11223344);
    check_output("wrap_aligned_addr", {25'd0, wr_addr}, 32'h7C);
    repeat (4) tick();
    check_output("wrap_ready_again", {31'd0, in_ready}, 32'd1);
    send_word(32'h55667788);
    check_output("wrap_to_zero", {16'd0, wr_en, wr_addr, wr_data}, {16'd0, 1'b1, 7'h00, 8'h55});
    repeat (4) tick();
    check_output("wrap_done", {31'd0, done}, 32'd1);
    check_output("wrap_mem_top", {mem[8'h7C], mem[8'h7D], mem[8'h7E], mem[8'h7F]}, 32'h11223344);
    check_output("wrap_mem_low", {mem[8'h00], mem[8'h01], mem[8'h02], mem[8'h03]}, 32'h55667788);
    tick();

    $display("[TB] full load");
    wc0 = wr_count;
    dc0 = done_count;
    for (int i = 0; i < 128; i++) hits0[i] = hits[i];
    apply_stimulus(7'h10, 6'd0);
    for (int i = 0; i < 32; i++) begin
      send_word(32'hC0000000 | i);
      repeat (4) tick();
    end
    tick();
    check_output("full_write_count", wr_count - wc0, 32'd128);
    check_output("full_done_count", done_count - dc0, 32'd1);
    check_output("full_words_loaded", {26'd0, words_loaded}, 32'd32);
    bad_addrs = 0;
    for (int i = 0; i < 128; i++) begin
      if (hits[i] - hits0[i] != 1) bad_addrs++;
    end
    check_output("full_each_addr_once", bad_addrs, 32'd0);
    check_output("full_mem", {mem[8'h10], mem[8'h13], mem[8'h0F], mem[8'h27]}, 32'hC0001F05);

    $display("[TB] abort");
    dc0 = done_count;
    apply_stimulus(7'h20, 6'd4);
    send_word(32'h01020304);
    repeat (4) tick();
    send_word(32'hA1A2A3A4);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_output("abort_outputs", {28'd0, wr_en, in_ready, busy, done}, 32'd0);
    repeat (3) tick();
    check_output("abort_no_done", done_count - dc0, 32'd0);
    check_output("abort_words_loaded", {26'd0, words_loaded}, 32'd1);
    check_output("abort_mem", {mem[8'h24], mem[8'h25], mem[8'h26], mem[8'h27]}, 32'hA1A20005);
    check_output("abort_word1_kept", {mem[8'h20], mem[8'h23], 16'd0}, 32'h01040000);

    $display("[TB] ignored start and reset");
    apply_stimulus(7'h40, 6'd2);
    check_output("restart_after_abort", {31'd0, in_ready}, 32'd1);
    send_word(32'h0D0E0F10);
    tick();
    base_addr  = 7'h00;
    load_len   = 6'd1;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    repeat (2) tick();
    check_output("start_ignored_len", {30'd0, in_ready, done}, 32'd2);
    send_word(32'h11121314);
    check_output("start_ignored_addr", {16'd0, wr_en, wr_addr, wr_data}, {16'd0, 1'b1, 7'h44, 8'h11});
    tick();
    wc0   = wr_count;
    rst_n = 1'b0;
    #1;
    check_output("async_reset_outputs", {16'd0, in_ready, wr_en, busy, done, wr_addr, wr_data, words_loaded}, 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check_output("reset_no_writes", wr_count - wc0, 32'd0);
    check_output("reset_idle", {29'd0, in_ready, busy, wr_en}, 32'd0);
    check_output("no_stray_writes", bad_wr, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/im_loader.md
# im_loader

Sequential writer for the 128-byte, byte-addressed, big-endian instruction memory. It accepts 32-bit instruction words over a valid/ready stream and writes each word as four byte writes, most significant byte first, into the memory's byte write port. The CPU fetch path reads the same array with the same big-endian layout. The loader is used at boot or test time to program instructions before the CPU is released.

## Interface
Parameters:
- MEM_SIZE, 128, memory size in bytes; must be a power of two and a multiple of 4.
- ADDR_W, 7, byte-address width; equals log2(MEM_SIZE).

Ports:
- clk  in  1  sole clock; everything is sampled on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load_start  in  1  single-cycle request to begin a load; honoured only in IDLE.
- base_addr  in  ADDR_W  start byte address, sampled with load_start; bits [1:0] are ignored, so the address is forced word-aligned.
- load_len  in  6  number of words to load, sampled with load_start; 0 means MEM_SIZE/4 (32) words.
- abort  in  1  synchronous cancel; wins over every other input.
- in_valid  in  1  in_word is valid.
- in_word  in  32  instruction word.
- in_ready  out  1  loader can accept in_word.
- wr_en  out  1  byte write strobe to the memory.
- wr_addr  out  ADDR_W  byte address of the write.
- wr_data  out  8  byte to write.
- busy  out  1  a load is in progress (ACCEPT or WRITE).
- done  out  1  one-cycle pulse after the last byte of a load is written.
- words_loaded  out  6  words fully written in the current or most recent load.

## Operation
- States: IDLE, ACCEPT, WRITE, DONE. The state, address, byte index, word counter and latched word are all registered.
- IDLE:
  - in_ready=0, busy=0.
  - On load_start: addr ← {base_addr[ADDR_W-1:2],2'b00}, len ← load_len (0 maps to 32), words_loaded ← 0, go to ACCEPT.
- ACCEPT:
  - in_ready=1, busy=1.
  - On in_valid&in_ready: latch in_word, byte_idx ← 0, go to WRITE. Otherwise stay; in_valid may stall indefinitely.
- WRITE:
  - in_ready=0, busy=1.
  - Each cycle: wr_en=1, wr_addr=addr, wr_data=word[31-8·byte_idx -: 8], then addr ← addr+1 modulo MEM_SIZE (0x7F wraps to 0x00), and byte_idx increments.
  - After byte_idx 3, words_loaded increments. If words_loaded+1==len go to DONE, else go to ACCEPT.
- DONE: done=1, busy=0, go to IDLE next cycle.
- Ignored inputs:
  - load_start is ignored outside IDLE.
  - in_valid is ignored outside ACCEPT; no word is consumed.
- abort: in any state, the next state is IDLE, and done is not pulsed.
  - A partially written word keeps the bytes already written.
  - words_loaded keeps the count of complete words.
- Address wrap: a load longer than the space to the end of memory wraps to address 0. A 32-word load overwrites the whole memory exactly once.
- wr_en, wr_addr and wr_data are registered outputs; in_ready, busy and done are decoded from the state register.

## Timing
- Reset values: state=IDLE, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, words_loaded=0.
- Reset is asynchronous. Asserting rst_n=0 mid-load returns every output to its reset value immediately, with no further writes.
- load_start sampled at edge T: ACCEPT and in_ready=1 from cycle T+1.
- Handshake at edge A: wr_en=1 in cycles A+1 through A+4, with bytes in MSB-first order at addresses addr..addr+3.
  - Non-final word: in_ready=1 again in cycle A+5.
  - Final word: done=1 in cycle A+5; IDLE from A+6, and load_start is accepted at edge A+6.
- Throughput: 5 cycles per word with no stalls. An N-word load with in_valid held high takes 5N+1 cycles from load_start to done.
- abort sampled at edge B: wr_en=0, in_ready=0 and busy=0 from cycle B+1.
- wr_en is never high in IDLE, ACCEPT or DONE.

## Test plan
- Single word: base 0x00, len 1, word 0x8C010004 → writes (0x00,0x8C),(0x01,0x01),(0x02,0x00),(0x03,0x04) on consecutive cycles; done 5 cycles after the handshake; words_loaded=1.
- Backpressure: len 3, in_valid low for 4 cycles before each word → in_ready stays high while waiting, no wr_en pulses while waiting; 12 byte writes at 0x00..0x0B; words_loaded=3.
- Wrap and alignment: base 0x7E (aligns to 0x7C), len 2, words 0x11223344 and 0x55667788 → bytes to 0x7C..0x7F, then 0x55,0x66,0x77,0x88 to 0x00..0x03.
- Full load: base 0x10, load_len 0 → exactly 128 writes covering every address once; done asserted once; words_loaded=32.
- Abort: abort at the third write cycle of word 2 (len 4) → only bytes 0–1 of word 2 written; no done; words_loaded=1; next load_start accepted.
- Reset mid-WRITE: rst_n low for 1 cycle → all outputs 0 at once; a load_start issued during a load is ignored and does not alter addr or len.
